instruction_sequencer: RTL and testbench

- Controller-sequencer for the 8-bit SAP machine.
- Runs a fixed 6-state T-cycle ring and decodes the instruction register's opcode nibble.
- Drives every bus and load control in the datapath, including the program counter's increment and tri-state output enable.
- Sits directly upstream of the program counter, MAR, RAM, IR, A/B registers, ALU and output register.

---
 rtl/sap_pkg.sv | 36 +++
 rtl/instruction_sequencer_if.sv | 37 +++
 rtl/ring_counter.sv | 33 +++
 rtl/instruction_sequencer.sv | 120 ++++++++++++
 tb/tb_instruction_sequencer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// Shared opcodes, T-state indices and the control-word layout for the SAP sequencer.
package sap_pkg;

    localparam int unsigned OPCODE_W  = 4;
    localparam int unsigned T_STATE_N = 6;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    // Bit positions in the one-hot T-state vector
    localparam int unsigned T1 = 0;
    localparam int unsigned T2 = 1;
    localparam int unsigned T3 = 2;
    localparam int unsigned T4 = 3;
    localparam int unsigned T5 = 4;
    localparam int unsigned T6 = 5;

    typedef struct packed {
        logic pc_increment;
        logic pc_enable_out;
        logic mar_load;
        logic ram_enable_out;
        logic ir_load;
        logic ir_enable_out;
        logic a_load;
        logic a_enable_out;
        logic alu_subtract;
        logic alu_enable_out;
        logic b_load;
        logic out_load;
    } ctrl_word_t;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Opcode in, datapath controls out; master is the sequencer, slave is the datapath.
interface instruction_sequencer_if;
    import sap_pkg::*;

    logic [OPCODE_W-1:0]  i_opcode;
    logic                 o_pc_increment;
    logic                 o_pc_enable_out;
    logic                 o_mar_load;
    logic                 o_ram_enable_out;
    logic                 o_ir_load;
    logic                 o_ir_enable_out;
    logic                 o_a_load;
    logic                 o_a_enable_out;
    logic                 o_alu_subtract;
    logic                 o_alu_enable_out;
    logic                 o_b_load;
    logic                 o_out_load;
    logic                 o_halt;
    logic [T_STATE_N-1:0] o_t_state;

    modport master (
        input  i_opcode,
        output o_pc_increment, o_pc_enable_out, o_mar_load, o_ram_enable_out,
               o_ir_load, o_ir_enable_out, o_a_load, o_a_enable_out,
               o_alu_subtract, o_alu_enable_out, o_b_load, o_out_load,
               o_halt, o_t_state
    );

    modport slave (
        output i_opcode,
        input  o_pc_increment, o_pc_enable_out, o_mar_load, o_ram_enable_out,
               o_ir_load, o_ir_enable_out, o_a_load, o_a_enable_out,
               o_alu_subtract, o_alu_enable_out, o_b_load, o_out_load,
               o_halt, o_t_state
    );

endinterface

// File: rtl/ring_counter.sv
// One-hot rotating T-state counter; resets to bit 0 and freezes while hold is high.
module ring_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Rotate one position toward the MSB unless held
    always_comb begin
        state_d = state_q;
        if (!hold) begin
            state_d = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WIDTH'(1);
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/instruction_sequencer.sv
// SAP controller-sequencer: T-state ring, halt flag and Moore control decode.
module instruction_sequencer
    import sap_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = OPCODE_W,
    parameter int unsigned T_STATES     = T_STATE_N
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    instruction_sequencer_if.master bus
);

    // The decode below is written for exactly six T-states and a 4-bit opcode
    if (T_STATES != 6 || OPCODE_WIDTH != OPCODE_W) begin : g_bad_cfg
        $error("instruction_sequencer: only T_STATES=6 and OPCODE_WIDTH=4 are supported");
    end

    logic [T_STATES-1:0] t_state;
    logic                halt_q;
    logic                halt_d;
    ctrl_word_t          cw;

    ring_counter #(.WIDTH(T_STATES)) u_ring (
        .clk     (i_clock),
        .rst_n   (i_reset_n),
        .hold    (halt_q),
        .state_o (t_state)
    );

    // Halt latches on the edge ending T4 of an HLT; only reset clears it
    always_comb begin
        halt_d = halt_q;
        if (t_state[T4] && bus.i_opcode == OP_HLT) begin
            halt_d = 1'b1;
        end
    end

    // Halt flag register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    // Control decode from T-state, halt and opcode; forced idle in reset or halt
    always_comb begin
        cw = '0;
        if (i_reset_n && !halt_q) begin
            if (t_state[T1]) begin
                cw.pc_enable_out = 1'b1;
                cw.mar_load      = 1'b1;
            end
            if (t_state[T2]) begin
                cw.pc_increment = 1'b1;
            end
            if (t_state[T3]) begin
                cw.ram_enable_out = 1'b1;
                cw.ir_load        = 1'b1;
            end
            if (t_state[T4]) begin
                case (bus.i_opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw.ir_enable_out = 1'b1;
                        cw.mar_load      = 1'b1;
                    end
                    OP_OUT: begin
                        cw.a_enable_out = 1'b1;
                        cw.out_load     = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (t_state[T5]) begin
                case (bus.i_opcode)
                    OP_LDA: begin
                        cw.ram_enable_out = 1'b1;
                        cw.a_load         = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw.ram_enable_out = 1'b1;
                        cw.b_load         = 1'b1;
                    end
                    default: ;
                endcase
            end
            if (t_state[T6]) begin
                case (bus.i_opcode)
                    OP_ADD: begin
                        cw.alu_enable_out = 1'b1;
                        cw.a_load         = 1'b1;
                    end
                    OP_SUB: begin
                        cw.alu_enable_out = 1'b1;
                        cw.a_load         = 1'b1;
                        cw.alu_subtract   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_pc_increment   = cw.pc_increment;
    assign bus.o_pc_enable_out  = cw.pc_enable_out;
    assign bus.o_mar_load       = cw.mar_load;
    assign bus.o_ram_enable_out = cw.ram_enable_out;
    assign bus.o_ir_load        = cw.ir_load;
    assign bus.o_ir_enable_out  = cw.ir_enable_out;
    assign bus.o_a_load         = cw.a_load;
    assign bus.o_a_enable_out   = cw.a_enable_out;
    assign bus.o_alu_subtract   = cw.alu_subtract;
    assign bus.o_alu_enable_out = cw.alu_enable_out;
    assign bus.o_b_load         = cw.b_load;
    assign bus.o_out_load       = cw.out_load;
    assign bus.o_halt           = halt_q;
    assign bus.o_t_state        = t_state;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: stimulus queues expectations, monitor compares.
module tb_instruction_sequencer;

    // Control-word bit order: pc_inc pc_en mar ram_en ir_ld ir_en a_ld a_en sub alu_en b_ld out_ld
    localparam logic [11:0] C_T1   = 12'b0110_0000_0000;
    localparam logic [11:0] C_T2   = 12'b1000_0000_0000;
    localparam logic [11:0] C_T3   = 12'b0001_1000_0000;
    localparam logic [11:0] C_ADDR = 12'b0010_0100_0000;
    localparam logic [11:0] C_OUT4 = 12'b0000_0001_0001;
    localparam logic [11:0] C_LDA5 = 12'b0001_0010_0000;
    localparam logic [11:0] C_ALU5 = 12'b0001_0000_0010;
    localparam logic [11:0] C_ADD6 = 12'b0000_0010_0100;
    localparam logic [11:0] C_SUB6 = 12'b0000_0010_1100;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    event async_ev;

    logic [18:0] exp_q[$];
    string       name_q[$];

    instruction_sequencer_if bus_if ();

    instruction_sequencer dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected controls for T-state index k (0 = T1) under opcode op
    function automatic logic [11:0] exp_cw(input int k, input logic [3:0] op);
        case (k)
            0: return C_T1;
            1: return C_T2;
            2: return C_T3;
            3: begin
                if (op == 4'b0000 || op == 4'b0001 || op == 4'b0010) return C_ADDR;
                if (op == 4'b1110) return C_OUT4;
                return 12'h000;
            end
            4: begin
                if (op == 4'b0000) return C_LDA5;
                if (op == 4'b0001 || op == 4'b0010) return C_ALU5;
                return 12'h000;
            end
            default: begin
                if (op == 4'b0001) return C_ADD6;
                if (op == 4'b0010) return C_SUB6;
                return 12'h000;
            end
        endcase
    endfunction

    function automatic void expect_state(input string nm, input logic [5:0] t,
                                         input logic [11:0] cw, input logic h);
        exp_q.push_back({t, cw, h});
        name_q.push_back(nm);
    endfunction

    function automatic logic [11:0] act_cw();
        return {bus_if.o_pc_increment, bus_if.o_pc_enable_out, bus_if.o_mar_load,
                bus_if.o_ram_enable_out, bus_if.o_ir_load, bus_if.o_ir_enable_out,
                bus_if.o_a_load, bus_if.o_a_enable_out, bus_if.o_alu_subtract,
                bus_if.o_alu_enable_out, bus_if.o_b_load, bus_if.o_out_load};
    endfunction

    // Pop one expectation and compare against the live outputs
    function automatic void check_now();
        logic [18:0] e;
        logic [18:0] a;
        string       nm;
        if (exp_q.size() == 0) return;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {bus_if.o_t_state, act_cw(), bus_if.o_halt};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got t=%b cw=%b halt=%b, want t=%b cw=%b halt=%b",
                     nm, a[18:13], a[12:1], a[0], e[18:13], e[12:1], e[0]);
        end
    endfunction

    // Monitor: bus exclusivity every cycle, plus scoreboard pop
    always @(negedge clk) begin
        logic [4:0] drv;
        drv = {bus_if.o_pc_enable_out, bus_if.o_ram_enable_out, bus_if.o_ir_enable_out,
               bus_if.o_a_enable_out, bus_if.o_alu_enable_out};
        tests++;
        assert ($onehot0(drv)) else begin
            fails++;
            $display("FAIL bus_exclusive: got drivers=%b, want at most one high", drv);
        end
        check_now();
    end

    // Asynchronous-reset sample point between clock edges
    always @(async_ev) check_now();

    // One instruction (or its first n states); starts and ends just after an edge
    task automatic instr(input string nm, input logic [3:0] op, input bit noise, input int n);
        for (int k = 0; k < n; k++) begin
            if (k < 3 && noise) bus_if.i_opcode = 4'($urandom_range(0, 15));
            else                bus_if.i_opcode = op;
            expect_state($sformatf("%s_T%0d", nm, k + 1), 6'(1) << k, exp_cw(k, op), 1'b0);
            if (k != n - 1 || n == 6) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Reset asserted mid-cycle, checked before any edge, then released in T1
    task automatic do_reset(input string nm);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        expect_state({nm, "_async"}, 6'b000001, 12'h000, 1'b0);
        #1;
        -> async_ev;
        @(posedge clk);
        #1;
        expect_state({nm, "_held"}, 6'b000001, 12'h000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus_if.i_opcode = 4'b0000;

        do_reset("por");
        instr("ring_lda0", 4'b0000, 1'b0, 6);
        instr("lda", 4'b0000, 1'b1, 6);
        instr("add", 4'b0001, 1'b1, 6);
        instr("sub", 4'b0010, 1'b1, 6);
        instr("nop7", 4'b0111, 1'b1, 6);
        instr("add_cut", 4'b0001, 1'b1, 5);
        do_reset("rst_t5");
        instr("lda_after", 4'b0000, 1'b1, 6);
        instr("out", 4'b1110, 1'b1, 6);
        instr("hlt", 4'b1111, 1'b1, 4);
        for (int i = 0; i < 21; i++) begin
            @(posedge clk);
            #1;
            bus_if.i_opcode = 4'($urandom_range(0, 15));
            expect_state($sformatf("halted_%0d", i), 6'b010000, 12'h000, 1'b1);
        end
        do_reset("rst_halt");
        instr("fetch_resume", 4'b0001, 1'b1, 6);

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
